// File: rtl/mem_arb_ctrl.sv
// Two-port (dcache/icache) arbiter for a single-outstanding memory channel.
// The dcache has priority, but the icache is forced through after STARVE_LIMIT consecutive losses.
module mem_arb_ctrl #(
    parameter int unsigned ADDRESS_WIDTH    = 32,
    parameter int unsigned CACHE_LINE_WIDTH = 128,
    parameter int unsigned STARVE_LIMIT     = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_d,
    input  logic                        req_i,
    input  logic                        write_d,
    input  logic                        write_i,
    input  logic [ADDRESS_WIDTH-1:0]    addr_d,
    input  logic [ADDRESS_WIDTH-1:0]    addr_i,
    input  logic [CACHE_LINE_WIDTH-1:0] data_d,
    input  logic [CACHE_LINE_WIDTH-1:0] data_i,
    input  logic                        mem_fill_valid,
    output logic                        mem_req,
    output logic                        mem_store,
    output logic [ADDRESS_WIDTH-1:0]    mem_addr,
    output logic [CACHE_LINE_WIDTH-1:0] mem_data,
    output logic                        grant_d,
    output logic                        grant_i,
    output logic                        busy,
    output logic                        proto_err
);

    localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e          state_q;
    logic            owner_i_q;
    logic [CntW-1:0] starve_cnt_q;
    logic            pick_i;

    // The icache wins when it is alone, or when it has lost too many times in a row.
    assign pick_i = req_i && (!req_d || (starve_cnt_q == StarveMax));

    assign grant_d = (state_q == StWait) && mem_fill_valid && !owner_i_q;
    assign grant_i = (state_q == StWait) && mem_fill_valid && owner_i_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            owner_i_q    <= 1'b0;
            starve_cnt_q <= '0;
            mem_req      <= 1'b0;
            mem_store    <= 1'b0;
            mem_addr     <= '0;
            mem_data     <= '0;
            busy         <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            mem_req <= 1'b0;
            // A completion can only be legal while a transaction is outstanding.
            if (mem_fill_valid && (state_q != StWait)) begin
                proto_err <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (req_d || req_i) begin
                        owner_i_q <= pick_i;
                        mem_store <= pick_i ? write_i : write_d;
                        mem_addr  <= pick_i ? addr_i : addr_d;
                        mem_data  <= pick_i ? data_i : data_d;
                        if (pick_i) begin
                            starve_cnt_q <= '0;
                        end else if (req_i && (starve_cnt_q != StarveMax)) begin
                            starve_cnt_q <= starve_cnt_q + CntW'(1);
                        end
                        mem_req <= 1'b1;
                        busy    <= 1'b1;
                        state_q <= StIssue;
                    end
                end
                StIssue: state_q <= StWait;
                StWait: begin
                    if (mem_fill_valid) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Scoreboard bench for mem_arb_ctrl: the stimulus queues the expected issue/grant,
// and a negedge monitor checks them whenever the DUT issues or grants.
module tb_mem_arb_ctrl;

    localparam int AW = 32;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_d = 1'b0, req_i = 1'b0, write_d = 1'b0, write_i = 1'b0;
    logic [AW-1:0] addr_d = '0, addr_i = '0;
    logic [DW-1:0] data_d = '0, data_i = '0;
    logic          mem_fill_valid = 1'b0;
    logic          mem_req, mem_store, grant_d, grant_i, busy, proto_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;

    typedef struct packed {
        logic          owner_i;
        logic          store;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    cmd_t issue_q[$];
    cmd_t grant_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    mem_arb_ctrl #(
        .ADDRESS_WIDTH   (AW),
        .CACHE_LINE_WIDTH(DW),
        .STARVE_LIMIT    (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_d         (req_d),
        .req_i         (req_i),
        .write_d       (write_d),
        .write_i       (write_i),
        .addr_d        (addr_d),
        .addr_i        (addr_i),
        .data_d        (data_d),
        .data_i        (data_i),
        .mem_fill_valid(mem_fill_valid),
        .mem_req       (mem_req),
        .mem_store     (mem_store),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .grant_d       (grant_d),
        .grant_i       (grant_i),
        .busy          (busy),
        .proto_err     (proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_txn(input logic owner_i, input logic store, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data, input bit with_grant);
        cmd_t c;
        c.owner_i = owner_i;
        c.store   = store;
        c.addr    = addr;
        c.data    = data;
        issue_q.push_back(c);
        if (with_grant) grant_q.push_back(c);
    endtask

    // Monitor: pops the scoreboard whenever the DUT issues or grants.
    always @(negedge clk) begin
        cmd_t e;
        if (mem_req) begin
            if (issue_q.size() == 0) begin
                check("unexpected_issue", 1'b1, 1'b0);
            end else begin
                e = issue_q.pop_front();
                check("issue_store", mem_store, e.store);
                check("issue_addr", mem_addr, e.addr);
                check("issue_data", mem_data, e.data);
            end
        end
        if (grant_d || grant_i) begin
            check("grant_onehot", grant_d & grant_i, 1'b0);
            if (grant_q.size() == 0) begin
                check("unexpected_grant", 1'b1, 1'b0);
            end else begin
                e = grant_q.pop_front();
                check("grant_owner", {grant_i, grant_d}, e.owner_i ? 2'b10 : 2'b01);
                check("grant_store", mem_store, e.store);
                check("grant_addr", mem_addr, e.addr);
                check("grant_data", mem_data, e.data);
            end
        end
    end

    // Memory model for one transaction: wait for the issue, optionally scramble the dcache
    // inputs while busy, then answer during the lat-th WAIT cycle.
    task automatic serve(input int lat, input bit scramble);
        int n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!mem_req) begin
            check("issue_timeout", 1'b0, 1'b1);
            return;
        end
        check("busy_in_issue", busy, 1'b1);
        if (scramble) begin
            data_d  = ~data_d;
            addr_d  = addr_d ^ 32'h0000_0ff0;
            write_d = ~write_d;
        end
        repeat (lat) @(posedge clk);
        #1 mem_fill_valid = 1'b1;
        @(posedge clk);
        #1 mem_fill_valid = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_mem_req"}, mem_req, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_mem_store"}, mem_store, 1'b0);
        check({tag, "_mem_addr"}, mem_addr, '0);
        check({tag, "_mem_data"}, mem_data, '0);
        check({tag, "_proto_err"}, proto_err, 1'b0);
        check({tag, "_grants"}, {grant_d, grant_i}, 2'b00);
    endtask

    initial begin
        // Reset held with a live request: reset must win.
        req_d = 1'b1;
        addr_d = 32'hffff_0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        req_d = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single icache fill answered after 5 idle WAIT cycles.
        req_i  = 1'b1;
        addr_i = 32'h0000_0100;
        data_i = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        expect_txn(1'b1, 1'b0, 32'h0000_0100, data_i, 1'b1);
        serve(6, 1'b0);
        req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Contention: dcache first, icache after DONE.
        req_d  = 1'b1;
        addr_d = 32'h0000_0400;
        data_d = 128'hd0;
        req_i  = 1'b1;
        addr_i = 32'h0000_0800;
        data_i = 128'h10;
        expect_txn(1'b0, 1'b0, 32'h0000_0400, 128'hd0, 1'b1);
        expect_txn(1'b1, 1'b0, 32'h0000_0800, 128'h10, 1'b1);
        serve(1, 1'b0);
        req_d = 1'b0;
        serve(2, 1'b0);
        req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Starvation: both held; four dcache wins, then icache is forced.
        req_d  = 1'b1;
        req_i  = 1'b1;
        addr_i = 32'h0000_2000;
        data_i = 128'h20;
        for (int k = 0; k < 4; k++) begin
            expect_txn(1'b0, 1'b0, 32'h0000_1000 + 32'(k * 64), 128'hd0, 1'b1);
        end
        expect_txn(1'b1, 1'b0, 32'h0000_2000, 128'h20, 1'b1);
        for (int k = 0; k < 5; k++) begin
            addr_d = 32'h0000_1000 + 32'(k * 64);
            serve(1, 1'b0);
        end
        req_d = 1'b0;
        req_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Eviction: command must stay latched while the dcache inputs change.
        req_d   = 1'b1;
        write_d = 1'b1;
        addr_d  = 32'h0000_2040;
        data_d  = 128'hdead_beef_cafe_f00d_0123_4567_89ab_cdef;
        expect_txn(1'b0, 1'b1, 32'h0000_2040, 128'hdead_beef_cafe_f00d_0123_4567_89ab_cdef, 1'b1);
        serve(4, 1'b1);
        req_d   = 1'b0;
        write_d = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("idle_keeps_addr", mem_addr, 32'h0000_2040);
        check("idle_keeps_store", mem_store, 1'b1);

        // Stray completion in IDLE.
        @(posedge clk);
        #1 mem_fill_valid = 1'b1;
        @(negedge clk);
        check("stray_fill_grants", {grant_d, grant_i}, 2'b00);
        @(posedge clk);
        #1 mem_fill_valid = 1'b0;
        @(negedge clk);
        check("stray_fill_proto_err", proto_err, 1'b1);
        check("stray_fill_busy", busy, 1'b0);

        // Reset while waiting on memory abandons the transaction.
        @(posedge clk);
        #1;
        req_d  = 1'b1;
        addr_d = 32'h0000_3000;
        data_d = 128'h33;
        expect_txn(1'b0, 1'b0, 32'h0000_3000, 128'h33, 1'b0);
        for (int n = 0; n < 20 && !mem_req; n++) @(negedge clk);
        check("abandon_issue_seen", mem_req, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        req_d = 1'b0;
        @(negedge clk);
        check("abandon_busy_in_wait", busy, 1'b1);
        @(negedge clk);
        check_idle_zero("mid_reset");
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 mem_fill_valid = 1'b1;
        @(negedge clk);
        check("late_fill_grants", {grant_d, grant_i}, 2'b00);
        @(posedge clk);
        #1 mem_fill_valid = 1'b0;
        @(negedge clk);
        check("late_fill_proto_err", proto_err, 1'b1);
        check("late_fill_busy", busy, 1'b0);

        repeat (2) @(negedge clk);
        check("issue_queue_drained", 32'(issue_q.size()), 32'd0);
        check("grant_queue_drained", 32'(grant_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
